// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a data-memory handshake and the MEM/WB register.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   MemWb[1:0]        WB controls from EX/MEM  {RegWrite, MemToReg}
//   MemMem[1:0]       MEM controls from EX/MEM {MemRead, MemWrite}
//   MemAluRes[31:0]   ALU result / byte address
//   MemWriteD[31:0]   store data
//   MemRd[4:0]        destination register
//   dmem_req/we/addr/wdata   data-memory request (outputs)
//   dmem_rdata/ready         data-memory response (inputs)
//   stall             hold upstream stages this cycle
//   WbWb/WbReadData/WbAluRes/WbRd   MEM/WB register outputs
//   mem_err           sticky misaligned / illegal / timeout flag
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemWb,
  input  logic [1:0]  MemMem,
  input  logic [31:0] MemAluRes,
  input  logic [31:0] MemWriteD,
  input  logic [4:0]  MemRd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic [1:0]  WbWb,
  output logic [31:0] WbReadData,
  output logic [31:0] WbAluRes,
  output logic [4:0]  WbRd,
  output logic        mem_err
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        err_q, err_d;
  logic [1:0]  wb_wb_q, wb_wb_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic op_present, aligned, is_read, pass;

  assign op_present = (MemMem == 2'b01) || (MemMem == 2'b10);
  assign aligned    = (MemAluRes[1:0] == 2'b00);
  assign is_read    = (MemMem == 2'b10);

  // Address/data are driven straight from EX/MEM; stall freezes them while waiting.
  assign dmem_we    = MemMem[0];
  assign dmem_addr  = {MemAluRes[31:2], 2'b00};
  assign dmem_wdata = MemWriteD;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    dmem_req = 1'b0;
    stall    = 1'b0;
    pass     = 1'b0;  // 1: MEM/WB takes the instruction, 0: MEM/WB takes a bubble
    unique case (state_q)
      StIdle: begin
        if (MemMem == 2'b00) begin
          pass = 1'b1;
        end else if (!op_present || !aligned) begin
          err_d = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            pass = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = StWait;
            wcnt_d  = 4'd0;
          end
        end
      end
      StWait: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          pass    = 1'b1;
          state_d = StIdle;
        end else if (wcnt_q == 4'd15) begin
          // Timeout: release the pipeline and drop the access.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          stall  = 1'b1;
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      dmem_req = 1'b0;
      stall    = 1'b0;
    end

    wb_wb_d    = pass ? MemWb : 2'b00;
    wb_alu_d   = pass ? MemAluRes : 32'd0;
    wb_rd_d    = pass ? MemRd : 5'd0;
    wb_rdata_d = (pass && is_read) ? dmem_rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wcnt_q     <= 4'd0;
      err_q      <= 1'b0;
      wb_wb_q    <= 2'b00;
      wb_rdata_q <= 32'd0;
      wb_alu_q   <= 32'd0;
      wb_rd_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      wb_wb_q    <= wb_wb_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign WbWb       = wb_wb_q;
  assign WbReadData = wb_rdata_q;
  assign WbAluRes   = wb_alu_q;
  assign WbRd       = wb_rd_q;
  assign mem_err    = err_q;

endmodule
